fetch_ctrl: RTL and testbench

- Instruction-fetch controller between the program-counter register and the IF/ID boundary.
- Takes the current PC (program-counter register Q) and issues one request at a time to a variable-latency instruction memory (req/ack).
- Captures the returned instruction into the IF/ID pipeline register.
- Drives the Stall input of the program-counter register, so the PC advances only when an instruction is accepted or a flush redirects it.

---
 rtl/fetch_ctrl_pkg.sv | 7 +
 rtl/fetch_ctrl_if_id_reg.sv | 31 +++
 rtl/fetch_ctrl.sv | 81 ++++++++
 tb/tb_fetch_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and defaults for the instruction-fetch controller
package fetch_ctrl_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'hD503201F;
  typedef enum logic [1:0] {LAUNCH = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;
endpackage

// File: rtl/fetch_ctrl_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush > stall > load > bubble priority
module if_id_reg import fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] q_pc,
  output logic [DATA_W-1:0] q_instr,
  output logic              q_valid
);
  always_ff @(posedge clk)
    if (!Reset) begin
      q_pc <= '0;
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (!stall) begin
      q_pc <= pc;
      q_instr <= instr;
      q_valid <= 1'b1;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-outstanding-request fetch FSM feeding the IF/ID register and stalling the PC
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Stall_ID,
  input  logic              Flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              PC_Stall,
  output logic [ADDR_W-1:0] IFID_PC,
  output logic [DATA_W-1:0] IFID_Instr,
  output logic              IFID_Valid
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] hold_buf;
  logic accept, stall_fsm;
  always_ff @(posedge clk)
    if (!Reset) begin
      state <= LAUNCH;
      req_addr <= '0;
      hold_buf <= '0;
    end else begin
      state <= state_nx;
      if (state == LAUNCH && !Flush) req_addr <= PC;
      if (state == FETCH && imem_ack && !Flush && Stall_ID) hold_buf <= imem_rdata;
    end
  always_comb begin
    state_nx = state;
    stall_fsm = 1'b1;
    accept = 1'b0;
    case (state)
      LAUNCH: begin
        stall_fsm = !Flush;
        state_nx = Flush ? LAUNCH : FETCH;
      end
      FETCH: begin
        // a flushed request still has to complete before the target may be issued
        if (Flush) begin
          stall_fsm = 1'b0;
          state_nx = imem_ack ? LAUNCH : DRAIN;
        end else if (imem_ack) begin
          accept = !Stall_ID;
          stall_fsm = Stall_ID;
          state_nx = Stall_ID ? HOLD : LAUNCH;
        end
      end
      HOLD: begin
        accept = !Stall_ID && !Flush;
        stall_fsm = Stall_ID && !Flush;
        state_nx = stall_fsm ? HOLD : LAUNCH;
      end
      DRAIN: begin
        stall_fsm = !Flush;
        state_nx = imem_ack ? LAUNCH : DRAIN;
      end
    endcase
  end
  assign PC_Stall = Reset && stall_fsm;
  assign imem_req = Reset && (state == FETCH || state == DRAIN);
  assign imem_addr = req_addr;
  if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk),
    .Reset(Reset),
    .flush(Flush),
    .stall(Stall_ID),
    .load(accept),
    .pc(req_addr),
    .instr(state == HOLD ? hold_buf : imem_rdata),
    .q_pc(IFID_PC),
    .q_instr(IFID_Instr),
    .q_valid(IFID_Valid)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table plus randomized run checked against program-order and memory-content rules
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic clk, Reset, Stall_ID, Flush, imem_req, imem_ack, PC_Stall, IFID_Valid;
  logic [31:0] PC, target, imem_addr, imem_rdata, IFID_PC, IFID_Instr;
  int tests, fails, accepted, wcnt, lat, lat_min, lat_max;
  logic p_stall, p_req, p_ack, p_v, pend;
  logic [31:0] p_addr, p_pc, p_in, pend_addr, exp_next;
  typedef struct {
    logic rst, st, fl;
    logic [31:0] tgt;
    logic e_stall, e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[31];

  fetch_ctrl dut (
    .clk(clk), .Reset(Reset), .PC(PC), .Stall_ID(Stall_ID), .Flush(Flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PC_Stall(PC_Stall), .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // memory: ack arrives lat cycles after req rises (lat=0 means same cycle)
  assign imem_ack = imem_req && (wcnt == lat);
  assign imem_rdata = mem_word(imem_addr);
  always_ff @(posedge clk)
    if (!Reset) begin
      wcnt <= 0;
      lat <= lat_min;
    end else if (imem_ack || !imem_req) begin
      wcnt <= 0;
      if (imem_ack) lat <= int'($urandom_range(lat_max, lat_min));
    end else wcnt <= wcnt + 1;

  always_ff @(posedge clk)
    if (!Reset) PC <= '0;
    else if (!PC_Stall) PC <= Flush ? target : PC + 32'd4;

  function automatic vec_t v(input logic r, s, f, input logic [31:0] t, input logic es, er,
                             input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    return '{r, s, f, t, es, er, ea, ev, ep};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp_v);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // one clock: drive, sample pre-edge, then judge the edge against the rules
  task automatic cyc(input logic r, s, f, input logic [31:0] t);
    @(negedge clk);
    Reset = r; Stall_ID = s; Flush = f; target = t;
    #2;
    p_stall = PC_Stall; p_req = imem_req; p_addr = imem_addr; p_ack = imem_ack;
    p_v = IFID_Valid; p_pc = IFID_PC; p_in = IFID_Instr;
    if (r && pend) begin
      chk1("req_held_until_ack", p_req, 1'b1);
      chk32("req_addr_stable", p_addr, pend_addr);
    end
    pend = r && p_req && !p_ack;
    pend_addr = p_addr;
    @(posedge clk);
    #1;
    if (!r) begin
      chk1("rst_pc_stall", p_stall, 1'b0);
      chk1("rst_req", p_req, 1'b0);
      chk1("rst_valid", IFID_Valid, 1'b0);
      chk32("rst_pc", IFID_PC, 32'h0);
      chk32("rst_instr", IFID_Instr, NOP);
      exp_next = 32'h0;
    end else if (f) begin
      chk1("flush_pc_stall", p_stall, 1'b0);
      chk1("flush_valid", IFID_Valid, 1'b0);
      chk32("flush_instr", IFID_Instr, NOP);
      exp_next = t;
    end else if (s) begin
      chk1("stall_pc_stall", p_stall, 1'b1);
      chk1("stall_hold_valid", IFID_Valid, p_v);
      chk32("stall_hold_pc", IFID_PC, p_pc);
      chk32("stall_hold_instr", IFID_Instr, p_in);
    end else begin
      chk1("pc_advance_iff_accept", p_stall, !IFID_Valid);
      if (IFID_Valid) begin
        chk32("program_order_pc", IFID_PC, exp_next);
        chk32("instr_content", IFID_Instr, mem_word(IFID_PC));
        exp_next = exp_next + 32'd4;
        accepted++;
      end else chk32("bubble_instr", IFID_Instr, NOP);
    end
  endtask

  initial begin
    tests = 0; fails = 0; accepted = 0; pend = 1'b0; exp_next = 32'h0;
    lat_min = 2; lat_max = 2;
    Reset = 1'b0; Stall_ID = 1'b0; Flush = 1'b0; target = 32'h0;
    tbl[0]  = v(0,0,0,32'h0,   0,0,32'h0,   0,32'h0);
    tbl[1]  = v(0,0,0,32'h0,   0,0,32'h0,   0,32'h0);
    tbl[2]  = v(0,0,0,32'h0,   0,0,32'h0,   0,32'h0);
    tbl[3]  = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h0);
    tbl[4]  = v(1,0,0,32'h0,   1,1,32'h0,   0,32'h0);
    tbl[5]  = v(1,0,0,32'h0,   1,1,32'h0,   0,32'h0);
    tbl[6]  = v(1,0,0,32'h0,   0,1,32'h0,   1,32'h0);
    tbl[7]  = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h0);
    tbl[8]  = v(1,0,0,32'h0,   1,1,32'h4,   0,32'h0);
    tbl[9]  = v(1,1,0,32'h0,   1,1,32'h4,   0,32'h0);
    tbl[10] = v(1,1,0,32'h0,   1,1,32'h4,   0,32'h0);
    tbl[11] = v(1,1,0,32'h0,   1,0,32'h0,   0,32'h0);
    tbl[12] = v(1,0,0,32'h0,   0,0,32'h0,   1,32'h4);
    tbl[13] = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h4);
    tbl[14] = v(1,0,1,32'h100, 0,1,32'h8,   0,32'h4);
    tbl[15] = v(1,0,0,32'h0,   1,1,32'h8,   0,32'h4);
    tbl[16] = v(1,0,0,32'h0,   1,1,32'h8,   0,32'h4);
    tbl[17] = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h4);
    tbl[18] = v(1,0,0,32'h0,   1,1,32'h100, 0,32'h4);
    tbl[19] = v(1,0,0,32'h0,   1,1,32'h100, 0,32'h4);
    tbl[20] = v(1,0,0,32'h0,   0,1,32'h100, 1,32'h100);
    tbl[21] = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h100);
    tbl[22] = v(1,0,0,32'h0,   1,1,32'h104, 0,32'h100);
    tbl[23] = v(1,0,0,32'h0,   1,1,32'h104, 0,32'h100);
    tbl[24] = v(1,0,1,32'h200, 0,1,32'h104, 0,32'h100);
    tbl[25] = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h100);
    tbl[26] = v(1,0,0,32'h0,   1,1,32'h200, 0,32'h100);
    tbl[27] = v(1,0,0,32'h0,   1,1,32'h200, 0,32'h100);
    tbl[28] = v(0,0,0,32'h0,   0,0,32'h0,   0,32'h0);
    tbl[29] = v(1,0,0,32'h0,   1,0,32'h0,   0,32'h0);
    tbl[30] = v(1,0,0,32'h0,   1,1,32'h0,   0,32'h0);
    for (int i = 0; i < 31; i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].tgt);
      chk1($sformatf("row%0d_pc_stall", i), p_stall, tbl[i].e_stall);
      chk1($sformatf("row%0d_req", i), p_req, tbl[i].e_req);
      if (tbl[i].e_req) chk32($sformatf("row%0d_addr", i), p_addr, tbl[i].e_addr);
      chk1($sformatf("row%0d_valid", i), IFID_Valid, tbl[i].e_valid);
      chk32($sformatf("row%0d_ifid_pc", i), IFID_PC, tbl[i].e_pc);
      chk32($sformatf("row%0d_ifid_instr", i), IFID_Instr,
            tbl[i].e_valid ? mem_word(tbl[i].e_pc) : NOP);
    end
    lat_min = 0; lat_max = 4;
    accepted = 0;
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
          32'($urandom_range(0, 1023)) << 2);
    chk1("liveness_accepts", accepted > 50, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
